crc_framer: RTL

Upstream stage of the CRC-8 link: accepts a byte stream split into frames by a `last` flag and computes a CRC-8 over each frame. The generator polynomial is programmable. The block forwards every data byte unchanged and appends the CRC as one extra byte that closes the frame. A receiver that runs the same CRC over data plus the appended byte gets a zero remainder. The block sits between the byte source and the CRC decoder/check stage.

---
 rtl/crc_pkg.sv | 13 +
 rtl/crc8_step.sv | 26 ++
 rtl/crc_framer.sv | 111 +++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC-8 constants and framer state encoding
package crc_pkg;

    localparam int unsigned CRC_W    = 8;
    localparam logic [7:0]  CRC_INIT = 8'h00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_CRC  = 2'd2
    } framer_state_e;

endpackage

// File: rtl/crc8_step.sv
// rtl/crc8_step.sv - one byte of MSB-first CRC-8 with programmable polynomial
module crc8_step
    import crc_pkg::*;
(
    input  logic [CRC_W-1:0] crc_in,
    input  logic [7:0]       byte_in,
    input  logic [CRC_W-1:0] gen,
    output logic [CRC_W-1:0] crc_out
);

    logic [CRC_W-1:0] c;

    // Fold the byte in, then shift out eight bits with polynomial feedback on the MSB
    always_comb begin
        c = crc_in ^ byte_in;
        for (int i = 0; i < 8; i++) begin
            if (c[CRC_W-1]) begin
                c = {c[CRC_W-2:0], 1'b0} ^ gen;
            end else begin
                c = {c[CRC_W-2:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc_framer.sv
// rtl/crc_framer.sv - forwards framed bytes and appends a CRC-8 byte per frame
module crc_framer
    import crc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        gen,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [CNT_W-1:0]  frame_cnt
);

    framer_state_e     state_q;
    logic [CRC_W-1:0]  crc_q;
    logic [CRC_W-1:0]  gen_q;
    logic              m_valid_q;
    logic [DATA_W-1:0] m_data_q;
    logic              m_last_q;
    logic [CNT_W-1:0]  frame_cnt_q;

    logic              out_free;
    logic              accept;
    logic [CRC_W-1:0]  step_crc_in;
    logic [CRC_W-1:0]  step_gen;
    logic [CRC_W-1:0]  crc_d;

    // Output register can take a new byte when empty or being drained this edge
    assign out_free = !m_valid_q || m_ready;
    assign s_ready  = (state_q != S_CRC) && out_free;
    assign accept   = s_valid && s_ready;

    // The first byte of a frame starts from CRC_INIT and uses the live polynomial,
    // which is captured into gen_q at that same edge
    assign step_crc_in = (state_q == S_IDLE) ? CRC_INIT : crc_q;
    assign step_gen    = (state_q == S_IDLE) ? gen : gen_q;

    crc8_step u_step (
        .crc_in  (step_crc_in),
        .byte_in (s_data[7:0]),
        .gen     (step_gen),
        .crc_out (crc_d)
    );

    // Frame FSM with registered output byte, running CRC and completed-frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            crc_q       <= CRC_INIT;
            gen_q       <= 8'h00;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (out_free) begin
                m_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        gen_q     <= gen;
                        crc_q     <= crc_d;
                        m_valid_q <= 1'b1;
                        m_data_q  <= s_data;
                        m_last_q  <= 1'b0;
                        state_q   <= s_last ? S_CRC : S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        crc_q     <= crc_d;
                        m_valid_q <= 1'b1;
                        m_data_q  <= s_data;
                        m_last_q  <= 1'b0;
                        if (s_last) begin
                            state_q <= S_CRC;
                        end
                    end
                end
                S_CRC: begin
                    if (out_free) begin
                        m_valid_q   <= 1'b1;
                        m_data_q    <= DATA_W'(crc_q);
                        m_last_q    <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + 1'b1;
                        crc_q       <= CRC_INIT;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign frame_cnt = frame_cnt_q;

endmodule
